// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: drives chacha_core init/next, buffers each 512-bit keystream block and
// XORs it word by word (word 0 = MSBs) onto a valid/ready stream; one cycle input-to-output.
// Optional macro CHACHA_PREFETCH_EN: a second buffer fetches the next block while the active one drains.
module chacha_stream_xor #(
  parameter int WORD_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [255:0]         key_i,
  input  logic [63:0]          iv_i,
  input  logic [63:0]          ctr_init_i,
  output logic                 core_init_o,
  output logic                 core_next_o,
  output logic [255:0]         core_key_o,
  output logic [63:0]          core_iv_o,
  output logic [63:0]          core_ctr_o,
  input  logic                 core_ready_i,
  input  logic [16*WORD_W-1:0] core_data_out_i,
  input  logic                 core_data_out_valid_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [WORD_W-1:0]    s_data_i,
  input  logic                 s_last_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [WORD_W-1:0]    m_data_o,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic [63:0]          blk_cnt_o
);
  localparam int BLK_W = 16 * WORD_W;

  typedef enum logic [2:0] {IDLE, PULSE, WAIT_LO, WAIT_HI, STREAM} state_t;

  state_t              state_q;
  logic                first_q;
  logic                eom_q;
  logic                ks_vld_q;
  logic [BLK_W-1:0]    ks_q;
  logic [3:0]          idx_q;
  logic [63:0]         blk_cnt_q;
  logic                core_init_q;
  logic                core_next_q;
  logic [255:0]        key_q;
  logic [63:0]         iv_q;
  logic [63:0]         ctr_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic [WORD_W-1:0]   m_data_q;
  logic [WORD_W-1:0]   ks_word;
  logic                xfer;
  logic                wrap;
  logic                done;
  logic                pf_idle;

`ifdef CHACHA_PREFETCH_EN
  typedef enum logic [1:0] {PF_IDLE, PF_PULSE, PF_LO, PF_HI} pf_state_t;
  pf_state_t           pf_q;
  logic [BLK_W-1:0]    pend_q;
  logic                pend_vld_q;
  assign pf_idle = (pf_q == PF_IDLE);
`else
  assign pf_idle = 1'b1;
`endif

  assign ks_word   = ks_q[(15 - int'(idx_q)) * WORD_W +: WORD_W];
  assign s_ready_o = (state_q == STREAM) && ks_vld_q && (!m_valid_q || m_ready_i);
  assign xfer      = s_valid_i && s_ready_o;
  assign wrap      = xfer && !s_last_i && (idx_q == 4'd15);
  // Message finished once the last word has left and no core request is still in flight.
  assign done      = eom_q && (!m_valid_q || m_ready_i) && pf_idle;

  assign core_init_o = core_init_q;
  assign core_next_o = core_next_q;
  assign core_key_o  = key_q;
  assign core_iv_o   = iv_q;
  assign core_ctr_o  = ctr_q;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_last_o    = m_last_q;
  assign busy_o      = (state_q != IDLE);
  assign blk_cnt_o   = blk_cnt_q;

  // Control FSM, core handshake, keystream buffers and registered output word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      eom_q       <= 1'b0;
      ks_vld_q    <= 1'b0;
      ks_q        <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      key_q       <= '0;
      iv_q        <= '0;
      ctr_q       <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
`ifdef CHACHA_PREFETCH_EN
      pf_q        <= PF_IDLE;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
`endif
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;

      if (xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_data_i ^ ks_word;
        m_last_q  <= s_last_i;
        idx_q     <= idx_q + 4'd1;
      end else if (m_ready_i) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            key_q     <= key_i;
            iv_q      <= iv_i;
            ctr_q     <= ctr_init_i;
            first_q   <= 1'b1;
            eom_q     <= 1'b0;
            ks_vld_q  <= 1'b0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
`ifdef CHACHA_PREFETCH_EN
            pf_q       <= PF_IDLE;
            pend_vld_q <= 1'b0;
`endif
            // Pulse straight away when the core can take it, else hold in PULSE.
            if (core_ready_i) begin
              core_init_q <= 1'b1;
              state_q     <= WAIT_LO;
            end else begin
              state_q <= PULSE;
            end
          end
        end
        PULSE: begin
          if (core_ready_i) begin
            core_init_q <= first_q;
            core_next_q <= !first_q;
            state_q     <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!core_ready_i) state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (core_ready_i && core_data_out_valid_i) begin
            ks_q      <= core_data_out_i;
            ks_vld_q  <= 1'b1;
            idx_q     <= '0;
            blk_cnt_q <= blk_cnt_q + 64'd1;
            first_q   <= 1'b0;
            state_q   <= STREAM;
`ifdef CHACHA_PREFETCH_EN
            pf_q      <= PF_PULSE;
`endif
          end
        end
        STREAM: begin
          if (xfer && s_last_i) begin
            // End of message beats word 15: leftover keystream is dropped, no next block.
            eom_q    <= 1'b1;
            ks_vld_q <= 1'b0;
          end else if (wrap) begin
`ifdef CHACHA_PREFETCH_EN
            if (pend_vld_q) begin
              ks_q       <= pend_q;
              pend_vld_q <= 1'b0;
              blk_cnt_q  <= blk_cnt_q + 64'd1;
              pf_q       <= PF_PULSE;
            end else begin
              ks_vld_q <= 1'b0;
            end
`else
            ks_vld_q <= 1'b0;
            if (core_ready_i) begin
              core_next_q <= 1'b1;
              state_q     <= WAIT_LO;
            end else begin
              state_q <= PULSE;
            end
`endif
          end
`ifdef CHACHA_PREFETCH_EN
          else if (!ks_vld_q && pend_vld_q && !eom_q) begin
            // Prefetch landed after the active block ran dry.
            ks_q       <= pend_q;
            ks_vld_q   <= 1'b1;
            pend_vld_q <= 1'b0;
            blk_cnt_q  <= blk_cnt_q + 64'd1;
            pf_q       <= PF_PULSE;
          end
`endif
          if (done) begin
            eom_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef CHACHA_PREFETCH_EN
      // Background fetch of the following block into the pending buffer.
      case (pf_q)
        PF_PULSE: if (core_ready_i) begin
          core_next_q <= 1'b1;
          pf_q        <= PF_LO;
        end
        PF_LO: if (!core_ready_i) pf_q <= PF_HI;
        PF_HI: if (core_ready_i && core_data_out_valid_i) begin
          pend_q     <= core_data_out_i;
          pend_vld_q <= !eom_q;
          pf_q       <= PF_IDLE;
        end
        default: pf_q <= PF_IDLE;
      endcase
`endif
    end
  end
endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: a behavioural ChaCha20 core answers init/next, and a
// scoreboard built from (key, iv, ctr + word/16) checks every output handshake.
// Literal ChaCha20 zero-key words pin the model; boundary, reset and busy-start cases are directed.
module tb_chacha_stream_xor;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [63:0]  iv;
  logic [63:0]  ctr_init;
  logic         core_init, core_next;
  logic [255:0] core_key;
  logic [63:0]  core_iv, core_ctr;
  logic         core_ready;
  logic [511:0] core_data_out;
  logic         core_data_out_valid;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         m_valid, m_ready, m_last;
  logic [31:0]  m_data;
  logic         busy;
  logic [63:0]  blk_cnt;

  always #5 clk = ~clk;

  chacha_stream_xor #(.WORD_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .key_i(key), .iv_i(iv), .ctr_init_i(ctr_init),
    .core_init_o(core_init), .core_next_o(core_next),
    .core_key_o(core_key), .core_iv_o(core_iv), .core_ctr_o(core_ctr),
    .core_ready_i(core_ready), .core_data_out_i(core_data_out),
    .core_data_out_valid_i(core_data_out_valid),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .busy_o(busy), .blk_cnt_o(blk_cnt)
  );

`ifdef CHACHA_PREFETCH_EN
  localparam logic BND_RDY  = 1'b1;
  localparam int   LAST15_NEXTS = 1;
`else
  localparam logic BND_RDY  = 1'b0;
  localparam int   LAST15_NEXTS = 0;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] expq[$];
  logic        explast[$];
  logic [31:0] outlog[$];
  logic [31:0] din[64];
  int init_cnt = 0;
  int next_cnt = 0;
  bit rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- ChaCha20 reference (byte-ordered output, word 0 in MSBs)
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction
  function automatic logic [511:0] chacha_blk(input logic [255:0] k, input logic [63:0] n,
                                              input logic [63:0] c);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] res;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c[31:0];  s[13] = c[63:32];
    s[14] = bswap(n[63:32]); s[15] = bswap(n[31:0]);
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[511-32*i -: 32] = bswap(x[i] + s[i]);
    return res;
  endfunction

  // Expected ciphertext for message words 0..npush-1 of an n-word message.
  task automatic load_exp(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c,
                          input int nwords, input int npush);
    logic [511:0] blk;
    logic [31:0]  w;
    for (int j = 0; j < npush; j++) begin
      blk = chacha_blk(k, n, c + 64'(j / 16));
      w   = blk[511-32*(j%16) -: 32];
      expq.push_back(din[j] ^ w);
      explast.push_back(j == nwords - 1);
    end
  endtask

  // ---------------- behavioural chacha_core
  initial begin
    logic [63:0]  mctr;
    logic [511:0] blk;
    core_ready = 1'b1; core_data_out_valid = 1'b0; core_data_out = '0; mctr = '0;
    forever begin
      @(negedge clk);
      if (core_init || core_next) begin
        if (core_init) mctr = core_ctr; else mctr = mctr + 64'd1;
        blk = chacha_blk(core_key, core_iv, mctr);
        @(posedge clk); #1;
        core_ready = 1'b0; core_data_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        core_data_out = blk; core_data_out_valid = 1'b1; core_ready = 1'b1;
      end
    end
  end

  // ---------------- output sink
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process
  initial begin
    logic        hold_v, idle_pend, l;
    logic [31:0] hold_d, e;
    hold_v = 1'b0; idle_pend = 1'b0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (core_init) init_cnt++;
      if (core_next) next_cnt++;
`ifndef CHACHA_PREFETCH_EN
      if (idle_pend && !rst) chk("idle_after_last", busy, 0);
`endif
      idle_pend = 1'b0;
      if (hold_v && !rst) begin
        chk("m_hold_valid", m_valid, 1);
        chk("m_hold_data", m_data, hold_d);
      end
      hold_v = m_valid && !m_ready && !rst;
      hold_d = m_data;
      if (m_valid && m_ready && !rst) begin
        outlog.push_back(m_data);
        if (expq.size() == 0) begin
          fail_now("m_unexpected_word");
        end else begin
          e = expq.pop_front();
          l = explast.pop_front();
          chk("m_data", m_data, e);
          chk("m_last", m_last, l);
          idle_pend = l;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic do_start(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
    key = k; iv = n; ctr_init = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int nwords, input int stop_at, input bit chk_bnd);
    for (int j = 0; j < nwords && j < stop_at; j++) begin
      int t;
      t = 0;
      s_valid = 1'b1; s_data = din[j]; s_last = (j == nwords - 1);
      @(negedge clk);
      while (!s_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) begin
        fail_now("s_ready_timeout");
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (chk_bnd && j == 15) begin
        @(negedge clk);
        chk("s_ready_after_w15", s_ready, BND_RDY);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain(input string name, input bit need_idle);
    int t;
    t = 0;
    while ((expq.size() != 0 || (need_idle && busy)) && t < 1000) begin
      @(negedge clk); t++;
    end
    if (t >= 1000) fail_now(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  // ---------------- directed sequence
  initial begin
    logic [511:0] b0;
    logic [255:0] kb;
    int i0, n0;
    rst = 1'b1; start = 1'b0; key = '0; iv = '0; ctr_init = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_next", core_next, 0);
    chk("rst_core_key", 64'(|core_key), 0);
    chk("rst_core_iv", core_iv, 0);
    chk("rst_core_ctr", core_ctr, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    @(posedge clk); #1;

    // Model pinned to published ChaCha20 zero-key keystream.
    b0 = chacha_blk('0, '0, '0);
    chk("model_w0", b0[511-:32], 32'h76b8e0ad);
    chk("model_w1", b0[479-:32], 32'ha0f13d90);

    // A: zero key/iv/ctr, zero plaintext -> raw keystream.
    din[0] = '0; din[1] = '0;
    outlog.delete();
    load_exp('0, '0, '0, 2, 2);
    do_start('0, '0, '0);
    @(negedge clk); chk("init_pulse_t1", core_init, 1);
    @(negedge clk); chk("init_pulse_gone", core_init, 0);
    send(2, 2, 1'b0);
    wait_drain("drain_a", 1'b1);
    chk("a_word0", outlog[0], 32'h76b8e0ad);
    chk("a_word1", outlog[1], 32'ha0f13d90);
    chk("a_blk_cnt", blk_cnt, 1);

    // B: 40-word message across three blocks; a start pulse mid-message must be ignored.
    kb = {4{64'h0123456789abcdef}};
    for (int j = 0; j < 40; j++) din[j] = $urandom;
    outlog.delete();
    load_exp(kb, 64'hdeadbeefcafebabe, '0, 40, 40);
    i0 = init_cnt;
    do_start(kb, 64'hdeadbeefcafebabe, '0);
    fork
      send(40, 40, 1'b1);
      begin
        repeat (25) @(posedge clk);
        #1 start = 1'b1; key = '0;
        @(posedge clk); #1 start = 1'b0;
        chk("b_busy_mid", busy, 1);
      end
    join
    wait_drain("drain_b", 1'b1);
    chk("b_blk_cnt", blk_cnt, 3);
    chk("b_init_count", 64'(init_cnt - i0), 1);
    chk("b_word_count", 64'(outlog.size()), 40);

    // C: random back-pressure, counter crossing the 32-bit boundary.
    rdy_rand = 1'b1;
    for (int j = 0; j < 33; j++) din[j] = $urandom;
    outlog.delete();
    load_exp({8{32'h5a5a1234}}, 64'h0011223344556677, 64'h00000000_fffffffe, 33, 33);
    do_start({8{32'h5a5a1234}}, 64'h0011223344556677, 64'h00000000_fffffffe);
    send(33, 33, 1'b0);
    wait_drain("drain_c", 1'b1);
    rdy_rand = 1'b0;
    chk("c_blk_cnt", blk_cnt, 3);
    chk("c_word_count", 64'(outlog.size()), 33);

    // D: s_last on word 15 suppresses the next-block request.
    for (int j = 0; j < 16; j++) din[j] = 32'h1000_0000 + 32'(j);
    load_exp(kb, 64'h1, 64'h7, 16, 16);
    n0 = next_cnt;
    do_start(kb, 64'h1, 64'h7);
    send(16, 16, 1'b0);
    wait_drain("drain_d", 1'b1);
    chk("d_next_count", 64'(next_cnt - n0), 64'(LAST15_NEXTS));
    chk("d_blk_cnt", blk_cnt, 1);

    // E: reset in STREAM with idx = 7, then a fresh start reproduces word 0.
    for (int j = 0; j < 20; j++) din[j] = 32'(j) * 32'h01010101;
    load_exp('0, '0, '0, 20, 7);
    do_start('0, '0, '0);
    send(20, 7, 1'b0);
    wait_drain("drain_e", 1'b0);
    chk("e_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("e_rst_m_valid", m_valid, 0);
    chk("e_rst_m_data", m_data, 0);
    chk("e_rst_s_ready", s_ready, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_blk_cnt", blk_cnt, 0);
    chk("e_rst_core_ctr", core_ctr, 0);
    chk("e_rst_core_init", core_init, 0);
    @(posedge clk); #1;
    din[0] = '0;
    outlog.delete();
    load_exp('0, '0, '0, 1, 1);
    do_start('0, '0, '0);
    send(1, 1, 1'b0);
    wait_drain("drain_f", 1'b1);
    chk("f_word0", outlog[0], 32'h76b8e0ad);
    chk("f_blk_cnt", blk_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
